miner_job_dispatcher: RTL and testbench
=======================================

MINER_JOB_DISPATCHER -- requirements
Module: miner_job_dispatcher

Interface
REQ-001 Parameter POLL_LIMIT, default 32'd16777216, max status reads per job before timeout.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 job_valid  in  1  job offered.
REQ-006 job_ready  out  1  dispatcher accepts job when job_valid & job_ready.
REQ-007 job_target  in  256  difficulty target.
REQ-008 job_header  in  608  block header minus nonce.
REQ-009 job_id  in  8  tag echoed with result.
REQ-010 masterAddr  out  5  miner register address.
REQ-011 masterWriteData  out  32  write data.
REQ-012 masterWrite, masterRead, masterChipSelect  out  1 each  bus strobes.
REQ-013 masterReadData  in  32  read data, valid the cycle after the read cycle.
REQ-014 result_valid  out  1; result_ready  in  1; result_nonce  out  32; result_id  out  8; result_timeout  out  1.

Function
REQ-015 States: IDLE, WR_TGT, TGT_CMD, WR_MSG, MSG_CMD, POLL_RD, POLL_CHK, NONCE_RD, NONCE_CHK, RESULT.
REQ-016 IDLE: job_ready=1; on handshake, latch target, header, id; go WR_TGT if target differs from cached target or cache invalid, else WR_MSG.
REQ-017 WR_TGT: 8 single-cycle writes, addr 9 down to 2, data job_target[255:224] down to [31:0].
REQ-018 TGT_CMD: one write addr 1, data 32'h1; set cache valid, store target; go WR_MSG.
REQ-019 WR_MSG: 19 single-cycle writes, addr 29-k, data header[607-32k -: 32], k=0..18.
REQ-020 MSG_CMD: one write addr 1, data 32'h2; clear poll counter; go POLL_RD.
REQ-021 POLL_RD: one read addr 0, increment poll counter; go POLL_CHK.
REQ-022 POLL_CHK: masterReadData==32'h3 -> NONCE_RD; else counter==POLL_LIMIT -> RESULT with timeout=1, nonce=0; else POLL_RD.
REQ-023 NONCE_RD: one read addr 10; NONCE_CHK captures masterReadData into result_nonce, timeout=0; go RESULT.
REQ-024 RESULT: result_valid=1, outputs stable until result_ready; on handshake go IDLE.
REQ-025 masterChipSelect=1 exactly in cycles with masterWrite or masterRead; write and read never simultaneous; strobes 0 in IDLE, *_CHK, RESULT.
REQ-026 job_ready=0 outside IDLE; job_valid ignored outside IDLE.
REQ-027 Timeout invalidates target cache (miner state unknown).
REQ-028 Poll counter 32 bits, no wrap; compare before increment beyond POLL_LIMIT.
REQ-029 Beat index counter 5 bits, cleared on each state entry.

Reset
REQ-030 rst: state IDLE, all strobes 0, masterAddr 0, masterWriteData 0, result_valid 0, result_nonce 0, result_id 0, result_timeout 0, cache invalid, counters 0.
REQ-031 rst mid-transaction aborts immediately; no bus strobe in the cycle after rst asserted; next job rewrites target.

Structure
REQ-032 Shared package holds miner register addresses (STATUS=0, CMD=1, TGT_LO=2, TGT_HI=9, NONCE=10, MSG_LO=11, MSG_HI=29), command codes (LOAD_TGT=1, START=2), STATUS_DONE=3, state enum.
REQ-033 Single module; no sub-module.

Verification
REQ-034 Target 256'h1000..0, header = empty-block test header, model DONE after 5 polls, nonce 42 -> 29 writes in order, 5 reads addr 0, 1 read addr 10, result_nonce=42, timeout=0.
REQ-035 Second job, same target, nonce 2 -> 20 writes only (addr 29..11, then 1<-2), result_nonce=2.
REQ-036 Job with target 256'h0100..0 -> target rewritten (addr 9 data 32'h01000000), result_nonce=32'h176.
REQ-037 POLL_LIMIT=16, model never DONE -> exactly 16 status reads, result_timeout=1, nonce 0; next job rewrites target.
REQ-038 rst asserted mid WR_MSG -> strobes 0 next cycle, job_ready=1; next same-target job performs full 29-write sequence.
REQ-039 result_ready held 0 for 5 cycles -> result_valid/nonce/id stable, job_ready=0, no bus activity.

Source files
------------

// File: rtl/miner_job_dispatcher_pkg.sv
// Miner job dispatcher shared definitions.
// Register map, command codes and FSM state encoding.
package miner_job_dispatcher_pkg;

  localparam logic [4:0] REG_STATUS = 5'd0;
  localparam logic [4:0] REG_CMD    = 5'd1;
  localparam logic [4:0] REG_TGT_LO = 5'd2;
  localparam logic [4:0] REG_TGT_HI = 5'd9;
  localparam logic [4:0] REG_NONCE  = 5'd10;
  localparam logic [4:0] REG_MSG_LO = 5'd11;
  localparam logic [4:0] REG_MSG_HI = 5'd29;

  localparam logic [31:0] CMD_LOAD_TGT = 32'd1;
  localparam logic [31:0] CMD_START    = 32'd2;
  localparam logic [31:0] STATUS_DONE  = 32'd3;

  localparam logic [4:0] TGT_LAST = 5'd7;
  localparam logic [4:0] MSG_LAST = 5'd18;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_TGT,
    S_TGT_CMD,
    S_WR_MSG,
    S_MSG_CMD,
    S_POLL_RD,
    S_POLL_CHK,
    S_NONCE_RD,
    S_NONCE_CHK,
    S_RESULT
  } state_e;

endpackage

// File: rtl/miner_job_dispatcher.sv
// Miner job dispatcher: loads target/header into the miner,
// polls for completion and returns the found nonce.
module miner_job_dispatcher
  import miner_job_dispatcher_pkg::*;
#(
  parameter logic [31:0] POLL_LIMIT = 32'd16777216
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_target,
  input  logic [607:0] job_header,
  input  logic [7:0]   job_id,
  output logic [4:0]   masterAddr,
  output logic [31:0]  masterWriteData,
  output logic         masterWrite,
  output logic         masterRead,
  output logic         masterChipSelect,
  input  logic [31:0]  masterReadData,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [31:0]  result_nonce,
  output logic [7:0]   result_id,
  output logic         result_timeout
);

  state_e       state_q, state_d;
  logic [4:0]   beat_q, beat_d;
  logic [31:0]  poll_q, poll_d;
  logic [255:0] tgt_q, tgt_d;
  logic [607:0] hdr_q, hdr_d;
  logic [7:0]   id_q, id_d;
  logic [255:0] ctgt_q, ctgt_d;
  logic         cvld_q, cvld_d;
  logic [31:0]  nonce_q, nonce_d;
  logic         tmo_q, tmo_d;

  assign result_nonce   = nonce_q;
  assign result_id      = id_q;
  assign result_timeout = tmo_q;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      poll_q  <= '0;
      tgt_q   <= '0;
      hdr_q   <= '0;
      id_q    <= '0;
      ctgt_q  <= '0;
      cvld_q  <= 1'b0;
      nonce_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      poll_q  <= poll_d;
      tgt_q   <= tgt_d;
      hdr_q   <= hdr_d;
      id_q    <= id_d;
      ctgt_q  <= ctgt_d;
      cvld_q  <= cvld_d;
      nonce_q <= nonce_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic and Moore bus strobes
  always_comb begin
    state_d          = state_q;
    poll_d           = poll_q;
    tgt_d            = tgt_q;
    hdr_d            = hdr_q;
    id_d             = id_q;
    ctgt_d           = ctgt_q;
    cvld_d           = cvld_q;
    nonce_d          = nonce_q;
    tmo_d            = tmo_q;
    job_ready        = 1'b0;
    result_valid     = 1'b0;
    masterAddr       = '0;
    masterWriteData  = '0;
    masterWrite      = 1'b0;
    masterRead       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          tgt_d = job_target;
          hdr_d = job_header;
          id_d  = job_id;
          if (!cvld_q || job_target != ctgt_q)
            state_d = S_WR_TGT;
          else
            state_d = S_WR_MSG;
        end
      end
      S_WR_TGT: begin
        masterWrite     = 1'b1;
        masterAddr      = REG_TGT_HI - beat_q;
        masterWriteData =
          tgt_q[8'd255 - {beat_q[2:0], 5'd0} -: 32];
        if (beat_q == TGT_LAST) state_d = S_TGT_CMD;
      end
      S_TGT_CMD: begin
        masterWrite     = 1'b1;
        masterAddr      = REG_CMD;
        masterWriteData = CMD_LOAD_TGT;
        cvld_d          = 1'b1;
        ctgt_d          = tgt_q;
        state_d         = S_WR_MSG;
      end
      S_WR_MSG: begin
        masterWrite     = 1'b1;
        masterAddr      = REG_MSG_HI - beat_q;
        masterWriteData =
          hdr_q[10'd607 - {beat_q, 5'd0} -: 32];
        if (beat_q == MSG_LAST) state_d = S_MSG_CMD;
      end
      S_MSG_CMD: begin
        masterWrite     = 1'b1;
        masterAddr      = REG_CMD;
        masterWriteData = CMD_START;
        poll_d          = '0;
        state_d         = S_POLL_RD;
      end
      S_POLL_RD: begin
        masterRead = 1'b1;
        masterAddr = REG_STATUS;
        if (poll_q != '1) poll_d = poll_q + 32'd1;
        state_d    = S_POLL_CHK;
      end
      S_POLL_CHK: begin
        if (masterReadData == STATUS_DONE) begin
          state_d = S_NONCE_RD;
        end else if (poll_q >= POLL_LIMIT) begin
          tmo_d   = 1'b1;
          nonce_d = '0;
          cvld_d  = 1'b0;
          state_d = S_RESULT;
        end else begin
          state_d = S_POLL_RD;
        end
      end
      S_NONCE_RD: begin
        masterRead = 1'b1;
        masterAddr = REG_NONCE;
        state_d    = S_NONCE_CHK;
      end
      S_NONCE_CHK: begin
        nonce_d = masterReadData;
        tmo_d   = 1'b0;
        state_d = S_RESULT;
      end
      S_RESULT: begin
        result_valid = 1'b1;
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    masterChipSelect = masterWrite | masterRead;
    beat_d = (state_d != state_q) ? 5'd0 : beat_q + 5'd1;
  end

endmodule

// File: tb/tb_miner_job_dispatcher.sv
// Directed bench for miner_job_dispatcher with a miner
// register model and bus/result scoreboards.
module tb_miner_job_dispatcher;

  typedef struct packed {
    logic        wr;
    logic [4:0]  a;
    logic [31:0] d;
  } op_t;

  typedef struct packed {
    logic [31:0] nonce;
    logic [7:0]  id;
    logic        tmo;
  } res_t;

  localparam logic [607:0] HDR = {
    32'h01000000,
    256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49,
    32'hffff001d
  };
  localparam logic [255:0] TGT_A = {32'h10000000, 224'h0};
  localparam logic [255:0] TGT_B = {32'h01000000, 224'h0};

  logic         clk = 1'b0;
  logic         rst;
  logic         job_valid;
  logic         job_ready;
  logic [255:0] job_target;
  logic [607:0] job_header;
  logic [7:0]   job_id;
  logic [4:0]   masterAddr;
  logic [31:0]  masterWriteData;
  logic         masterWrite;
  logic         masterRead;
  logic         masterChipSelect;
  logic [31:0]  masterReadData;
  logic         result_valid;
  logic         result_ready;
  logic [31:0]  result_nonce;
  logic [7:0]   result_id;
  logic         result_timeout;

  int checks = 0;
  int errors = 0;

  op_t  exp_q[$];
  res_t res_q[$];

  logic [31:0] m_rd_q = 32'h0;
  int          m_polls = 0;
  int          m_done_after = 0;
  logic [31:0] m_nonce = 32'h0;

  miner_job_dispatcher #(.POLL_LIMIT(32'd16)) dut (
    .clk              (clk),
    .rst              (rst),
    .job_valid        (job_valid),
    .job_ready        (job_ready),
    .job_target       (job_target),
    .job_header       (job_header),
    .job_id           (job_id),
    .masterAddr       (masterAddr),
    .masterWriteData  (masterWriteData),
    .masterWrite      (masterWrite),
    .masterRead       (masterRead),
    .masterChipSelect (masterChipSelect),
    .masterReadData   (masterReadData),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .result_nonce     (result_nonce),
    .result_id        (result_id),
    .result_timeout   (result_timeout)
  );

  always #5 clk = ~clk;

  assign masterReadData = m_rd_q;

  // Miner model: DONE after m_done_after status reads (0 = never)
  always @(posedge clk) begin
    if (masterWrite && masterAddr == 5'd1 &&
        masterWriteData == 32'd2)
      m_polls <= 0;
    if (masterRead) begin
      if (masterAddr == 5'd0) begin
        m_polls <= m_polls + 1;
        m_rd_q  <= (m_done_after != 0 &&
                    m_polls + 1 >= m_done_after) ?
                   32'd3 : 32'd0;
      end else if (masterAddr == 5'd10) begin
        m_rd_q <= m_nonce;
      end else begin
        m_rd_q <= 32'h0;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_job(input logic [255:0] t,
                          input logic [607:0] h,
                          input bit tgt_wr,
                          input int polls,
                          input bit tmo);
    if (tgt_wr) begin
      for (int i = 0; i < 8; i++)
        exp_q.push_back({1'b1, 5'(9 - i), t[255 - 32*i -: 32]});
      exp_q.push_back({1'b1, 5'd1, 32'd1});
    end
    for (int k = 0; k < 19; k++)
      exp_q.push_back({1'b1, 5'(29 - k), h[607 - 32*k -: 32]});
    exp_q.push_back({1'b1, 5'd1, 32'd2});
    for (int p = 0; p < polls; p++)
      exp_q.push_back({1'b0, 5'd0, 32'd0});
    if (!tmo) exp_q.push_back({1'b0, 5'd10, 32'd0});
  endtask

  task automatic observe_bus();
    op_t o;
    op_t e;
    check("busy_ready", 64'(job_ready), 64'd0);
    if (masterWrite || masterRead || masterChipSelect) begin
      check("cs", 64'(masterChipSelect),
            64'(masterWrite | masterRead));
      check("wr_rd_excl", 64'(masterWrite & masterRead), 64'd0);
      o = {masterWrite, masterAddr,
           masterWrite ? masterWriteData : 32'h0};
      check("op_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("bus_op", 64'(o), 64'(e));
      end
    end
  endtask

  task automatic offer_job(input logic [255:0] t,
                           input logic [607:0] h,
                           input logic [7:0] id);
    @(negedge clk);
    job_valid  = 1'b1;
    job_target = t;
    job_header = h;
    job_id     = id;
    check("idle_ready", 64'(job_ready), 64'd1);
    @(negedge clk);
    job_valid  = 1'b0;
    job_target = '1;
  endtask

  task automatic run_job(input logic [255:0] t,
                         input logic [7:0] id,
                         input bit tgt_wr,
                         input int polls,
                         input bit tmo,
                         input logic [31:0] nonce,
                         input int hold);
    int   n;
    res_t r;
    m_done_after = tmo ? 0 : polls;
    m_nonce      = nonce;
    push_job(t, HDR, tgt_wr, polls, tmo);
    res_q.push_back({tmo ? 32'h0 : nonce, id, tmo});
    offer_job(t, HDR, id);
    n = 0;
    while (!result_valid && n < 500) begin
      observe_bus();
      @(negedge clk);
      n++;
    end
    check("result_seen", 64'(result_valid), 64'd1);
    check("ops_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    r = res_q.pop_front();
    for (int c = 0; c <= hold; c++) begin
      check("res_valid", 64'(result_valid), 64'd1);
      check("res_nonce", 64'(result_nonce), 64'(r.nonce));
      check("res_id", 64'(result_id), 64'(r.id));
      check("res_tmo", 64'(result_timeout), 64'(r.tmo));
      check("res_ready", 64'(job_ready), 64'd0);
      check("res_cs", 64'(masterChipSelect), 64'd0);
      if (c < hold) @(negedge clk);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("post_valid", 64'(result_valid), 64'd0);
    check("post_ready", 64'(job_ready), 64'd1);
  endtask

  initial begin
    int n;
    rst          = 1'b1;
    job_valid    = 1'b0;
    job_target   = '0;
    job_header   = '0;
    job_id       = '0;
    result_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(job_ready), 64'd1);
    check("rst_strobes",
          64'({masterWrite, masterRead, masterChipSelect}), 64'd0);
    check("rst_addr", 64'(masterAddr), 64'd0);
    check("rst_wdata", 64'(masterWriteData), 64'd0);
    check("rst_rvalid", 64'(result_valid), 64'd0);
    check("rst_nonce", 64'(result_nonce), 64'd0);
    check("rst_id", 64'(result_id), 64'd0);
    check("rst_tmo", 64'(result_timeout), 64'd0);
    rst = 1'b0;

    run_job(TGT_A, 8'h11, 1'b1, 5, 1'b0, 32'd42, 0);
    run_job(TGT_A, 8'h22, 1'b0, 2, 1'b0, 32'd2, 0);
    run_job(TGT_B, 8'h33, 1'b1, 1, 1'b0, 32'h176, 0);
    run_job(TGT_B, 8'h44, 1'b0, 16, 1'b1, 32'h0, 0);
    run_job(TGT_B, 8'h55, 1'b1, 3, 1'b0, 32'h7, 5);

    offer_job(TGT_B, HDR, 8'h66);
    n = 0;
    while (!(masterWrite && masterAddr == 5'd20) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached", 64'(masterWrite && masterAddr == 5'd20),
          64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_strobes",
          64'({masterWrite, masterRead, masterChipSelect}), 64'd0);
    check("abort_ready", 64'(job_ready), 64'd1);
    check("abort_rvalid", 64'(result_valid), 64'd0);
    rst = 1'b0;
    exp_q.delete();

    run_job(TGT_B, 8'h77, 1'b1, 4, 1'b0, 32'h9, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
